seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a multi-digit common-anode 7-seg display.
//  Holds a packed hex value and steps through the digits, presenting one nibble per slot
//  on seg_num to the registered hex segment decoder and driving active-low digit selects.
//  Inserts a blanking window per slot to absorb decoder latency and avoid ghosting.
//  Value updates are double-buffered and applied only at frame boundaries.
// PARAMETERS
//  DIGITS  4      number of digits scanned, 1..8; digit 0 = value_in[3:0] (LSD)
//  DIV     50000  clk cycles per digit slot; DIV > BLANK
//  BLANK   16     cycles at start of each slot with all digits off; BLANK >= 1
// PORTS
//  clk        in   1         system clock
//  rst        in   1         reset
//  enable     in   1         1 = scanning, 0 = display dark, scan position held at digit 0
//  value_in   in   4*DIGITS  packed nibbles, sampled when load = 1
//  load       in   1         single-cycle update strobe
//  load_pend  out  1         1 = a loaded value awaits the next frame start
//  seg_num    out  4         nibble for current digit -> hex decoder input
//  dig_sel_n  out  DIGITS    active-low one-hot digit enable
//  frame_tick out  1         one-cycle pulse at each frame start
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - Reset (async, immediate): seg_num=0, dig_sel_n=all 1s, frame_tick=0, load_pend=0,
//    active and pending registers=0, digit index=0, slot counter=0, state=IDLE.
//  - Slot counter width $clog2(DIV); counts 0..DIV-1, then wraps to 0 and advances the index.
//  - Digit index wraps DIGITS-1 -> 0. The first cycle of the digit-0 slot is a frame start.
//  - FSM states:
//    - IDLE: entered on rst or enable=0. dig_sel_n=all 1s, counter/index=0.
//      IDLE -> BLANK on the first cycle enable=1; that cycle is slot 0 of digit 0 and is a
//      frame start.
//    - BLANK: slot count < BLANK. dig_sel_n=all 1s. seg_num=active[idx] from slot cycle 0.
//      BLANK -> SHOW when count reaches BLANK.
//    - SHOW: count in BLANK..DIV-1. dig_sel_n[idx]=0, all others 1.
//      SHOW -> BLANK at slot wrap.
//  - enable=0 in any state -> IDLE on the next edge, all digits off. Pending value is kept.
//  - Frame start:
//    - frame_tick=1 for exactly that cycle.
//    - If load_pend=1, active <= pending and load_pend clears.
//  - load:
//    - pending <= value_in; load_pend <= 1. The last load before a frame start wins.
//    - load on a frame-start cycle: the copy uses the prior pending contents; the new value
//      stays pending with load_pend=1 until the next frame start.
//    - load is accepted in IDLE and during reset release; it is never dropped.
//  - seg_num is registered and changes only at slot cycle 0. The decoder's 1-cycle latency
//    is covered by BLANK >= 1.
//  - Frame period = DIGITS*DIV cycles.
// CONFIGURATION
//  SEG_LZB_EN defined: leading-zero blanking.
//    - A digit i > 0 whose active nibble and all higher nibbles are 0 keeps dig_sel_n[i]=1
//      during SHOW.
//    - Digit 0 is always shown. Slot timing is unchanged.
//  SEG_LZB_EN undefined: every digit is lit during its SHOW window.
// TESTING (DIGITS=4, DIV=8, BLANK=2)
//  1. Reset: rst=1 mid-SHOW -> same cycle dig_sel_n=4'b1111, seg_num=0, frame_tick=0,
//     load_pend=0.
//  2. Basic scan: load 16'h1234 with enable=0, then enable=1.
//     - frame_tick on first enabled cycle; load_pend clears.
//     - Digit 0: seg_num=4, dig_sel_n=1111 on cycles 0-1, 1110 on cycles 2-7.
//     - Digits 1..3 then show 3/1101, 2/1011, 1/0111. frame_tick every 32 cycles.
//  3. Last load wins: load 16'h1111, then 16'h2222, both mid-frame -> next frame shows
//     only 2222; load_pend=1 until that frame start.
//  4. Load on frame start: load 16'hABCD on a frame_tick cycle -> current frame unchanged;
//     ABCD appears at the next frame_tick.
//  5. Enable drop: enable=0 during digit 2 SHOW -> next cycle dig_sel_n=1111.
//     Re-enable -> frame_tick, digit 0 BLANK.
//  6. LZB, SEG_LZB_EN defined:
//     - 16'h0050 -> digits 3,2 stay dark; digit 1 shows 5, digit 0 shows 0.
//     - 16'h0000 -> only digit 0 lit.
//     - With SEG_LZB_EN undefined, all four digits are lit.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if: value/strobe bundle between a display-value producer and the 7-seg
// scan controller, plus the scan outputs that drive the hex decoder and digit selects.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic                enable;
    logic [4*DIGITS-1:0] value_in;
    logic                load;
    logic                load_pend;
    logic [3:0]          seg_num;
    logic [DIGITS-1:0]   dig_sel_n;
    logic                frame_tick;

    modport master (
        output enable, value_in, load,
        input  load_pend, seg_num, dig_sel_n, frame_tick
    );

    modport slave (
        input  enable, value_in, load,
        output load_pend, seg_num, dig_sel_n, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode 7-seg display with
// per-slot blanking and frame-synchronous double-buffered value updates.
// Optional feature: define SEG_LZB_EN for leading-zero blanking of the upper digits.
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 16
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e        state_q,    state_d;
    logic [CW-1:0] slotCnt_q,  slotCnt_d;
    logic [IW-1:0] digIdx_q,   digIdx_d;
    logic [VW-1:0] active_q,   active_d;
    logic [VW-1:0] pending_q,  pending_d;
    logic          loadPend_q, loadPend_d;
    logic [3:0]    segNum_q,   segNum_d;

    logic              frameStart;
    logic [VW-1:0]     shownSrc;
    logic [DIGITS-1:0] litMask;
    logic [DIGITS-1:0] digSelN;
    logic              frameTick;

    assign frameStart = bus.enable && (slotCnt_q == '0) && (digIdx_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slotCnt_q  <= '0;
            digIdx_q   <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            loadPend_q <= 1'b0;
            segNum_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            slotCnt_q  <= slotCnt_d;
            digIdx_q   <= digIdx_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            loadPend_q <= loadPend_d;
            segNum_q   <= segNum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slotCnt_d  = slotCnt_q;
        digIdx_d   = digIdx_q;
        active_d   = active_q;
        pending_d  = pending_q;
        loadPend_d = loadPend_q;
        segNum_d   = segNum_q;
        shownSrc   = active_q;

        // A load coinciding with a frame start stays pending; the copy takes the older value.
        if (frameStart && loadPend_q) begin
            active_d = pending_q;
        end
        if (bus.load) begin
            pending_d  = bus.value_in;
            loadPend_d = 1'b1;
        end else if (frameStart) begin
            loadPend_d = 1'b0;
        end

        if (bus.enable) begin
            if (slotCnt_q == CNT_LAST) begin
                slotCnt_d = '0;
                digIdx_d  = (digIdx_q == IDX_LAST) ? '0 : digIdx_q + 1'b1;
            end else begin
                slotCnt_d = slotCnt_q + 1'b1;
            end
        end else begin
            slotCnt_d = '0;
            digIdx_d  = '0;
        end

        case (state_q)
            ST_IDLE, ST_BLANK: state_d = (slotCnt_d == CNT_BLANK) ? ST_SHOW : ST_BLANK;
            ST_SHOW:           state_d = (slotCnt_d == '0) ? ST_BLANK : ST_SHOW;
            default:           state_d = ST_IDLE;
        endcase
        if (!bus.enable) begin
            state_d = ST_IDLE;
        end

        // Preload the nibble for the coming slot 0, including the value a frame start will copy.
        if (slotCnt_d == '0) begin
            if (digIdx_d == '0 && loadPend_d) begin
                shownSrc = pending_d;
            end else begin
                shownSrc = active_d;
            end
            for (int d = 0; d < DIGITS; d++) begin
                if (digIdx_d == IW'(d)) begin
                    segNum_d = shownSrc[4*d +: 4];
                end
            end
        end
    end

`ifdef SEG_LZB_EN
    always_comb begin
        litMask    = '0;
        litMask[0] = 1'b1;
        for (int d = 1; d < DIGITS; d++) begin
            litMask[d] = |(active_q >> (4*d));
        end
    end
`else
    assign litMask = '1;
`endif

    always_comb begin
        digSelN   = '1;
        frameTick = frameStart && !rst;
        if (state_q == ST_SHOW) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (digIdx_q == IW'(d) && litMask[d]) begin
                    digSelN[d] = 1'b0;
                end
            end
        end
    end

    assign bus.seg_num    = segNum_q;
    assign bus.dig_sel_n  = digSelN;
    assign bus.frame_tick = frameTick;
    assign bus.load_pend  = loadPend_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with DIGITS=4, DIV=8, BLANK=2.
// Expected frame contents are queued as loads are driven and popped on each frame_tick.
module tb_seg_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checkCount = 0;
    int          passCount  = 0;
    logic [15:0] expQ[$];
    logic [15:0] cur = 16'h0000;

    seg_scan_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Digit select a correct display shows for digit d at slot cycle c of value v.
    function automatic logic [3:0] expSel(logic [15:0] v, int d, int c);
        logic [3:0] s;
        bit lit;
        s   = 4'b1111;
        lit = 1'b1;
        if (c < BLANK) return s;
`ifdef SEG_LZB_EN
        if (d > 0 && (v >> (4*d)) == 16'd0) lit = 1'b0;
`endif
        if (lit) s[d] = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] nib(logic [15:0] v, int d);
        return 4'(v >> (4*d));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = 16'h0000;
        rst          = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        bus.enable = 1'b1;
        repeat (4) step();
        bus.load     = 1'b1;
        bus.value_in = 16'h5A5A;
        step();
        bus.load = 1'b0;
        @(negedge clk);
        checkCount++;
        if (bus.dig_sel_n !== 4'b1110) $display("[TB] FAIL pre_reset_show: got %b expected %b", bus.dig_sel_n, 4'b1110);
        else passCount++;
        checkCount++;
        if (bus.load_pend !== 1'b1) $display("[TB] FAIL pre_reset_pend: got %b expected 1", bus.load_pend);
        else passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++;
        if (bus.dig_sel_n !== 4'b1111) $display("[TB] FAIL reset_dig_sel: got %b expected %b", bus.dig_sel_n, 4'b1111);
        else passCount++;
        checkCount++;
        if (bus.seg_num !== 4'h0) $display("[TB] FAIL reset_seg_num: got %h expected 0", bus.seg_num);
        else passCount++;
        checkCount++;
        if (bus.frame_tick !== 1'b0) $display("[TB] FAIL reset_frame_tick: got %b expected 0", bus.frame_tick);
        else passCount++;
        checkCount++;
        if (bus.load_pend !== 1'b0) $display("[TB] FAIL reset_load_pend: got %b expected 0", bus.load_pend);
        else passCount++;
        bus.enable = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_scan();
        bus.load     = 1'b1;
        bus.value_in = 16'h1234;
        expQ.push_back(16'h1234);
        step();
        bus.load = 1'b0;
        @(negedge clk);
        checkCount++;
        if (bus.load_pend !== 1'b1) $display("[TB] FAIL basic_pend_idle: got %b expected 1", bus.load_pend);
        else passCount++;
        step();
        bus.enable = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) step();
            @(negedge clk);
            if (bus.frame_tick === 1'b1 && expQ.size() > 0) cur = expQ.pop_front();
            checkCount++;
            if (bus.frame_tick !== ((k % 32) == 0)) $display("[TB] FAIL basic_tick_k%0d: got %b expected %b", k, bus.frame_tick, (k % 32) == 0);
            else passCount++;
            if (k == 1) begin
                checkCount++;
                if (bus.load_pend !== 1'b0) $display("[TB] FAIL basic_pend_clear: got %b expected 0", bus.load_pend);
                else passCount++;
            end
            if (k < 32) begin
                checkCount++;
                if (bus.seg_num !== nib(16'h1234, k / DIV)) $display("[TB] FAIL basic_seg_k%0d: got %h expected %h", k, bus.seg_num, nib(16'h1234, k / DIV));
                else passCount++;
                checkCount++;
                if (bus.dig_sel_n !== expSel(16'h1234, k / DIV, k % DIV)) $display("[TB] FAIL basic_sel_k%0d: got %b expected %b", k, bus.dig_sel_n, expSel(16'h1234, k / DIV, k % DIV));
                else passCount++;
            end
        end
    endtask

    task automatic test_last_load_wins();
        bit seen;
        seen = 1'b0;
        repeat (10) step();
        bus.load     = 1'b1;
        bus.value_in = 16'h1111;
        step();
        bus.value_in = 16'h2222;
        expQ.push_back(16'h2222);
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkCount++;
            if (bus.load_pend !== 1'b1) $display("[TB] FAIL last_pend_held_%0d: got %b expected 1", i, bus.load_pend);
            else passCount++;
            if (bus.frame_tick === 1'b1) begin
                if (expQ.size() > 0) cur = expQ.pop_front();
                seen = 1'b1;
                break;
            end
            step();
        end
        checkCount++;
        if (!seen) $display("[TB] FAIL last_tick_timeout: got no frame_tick expected one within 40 cycles");
        else passCount++;
        for (int k = 1; k < 32; k++) begin
            step();
            @(negedge clk);
            if (k == 1) begin
                checkCount++;
                if (bus.load_pend !== 1'b0) $display("[TB] FAIL last_pend_clear: got %b expected 0", bus.load_pend);
                else passCount++;
            end
            if (k % DIV == 4) begin
                checkCount++;
                if (bus.seg_num !== nib(cur, k / DIV)) $display("[TB] FAIL last_seg_d%0d: got %h expected %h", k / DIV, bus.seg_num, nib(cur, k / DIV));
                else passCount++;
                checkCount++;
                if (bus.dig_sel_n !== expSel(cur, k / DIV, 4)) $display("[TB] FAIL last_sel_d%0d: got %b expected %b", k / DIV, bus.dig_sel_n, expSel(cur, k / DIV, 4));
                else passCount++;
            end
        end
    endtask

    task automatic test_load_on_frame_start();
        bit seen;
        seen = 1'b0;
        step();
        bus.load     = 1'b1;
        bus.value_in = 16'hABCD;
        expQ.push_back(cur);
        expQ.push_back(16'hABCD);
        @(negedge clk);
        checkCount++;
        if (bus.frame_tick !== 1'b1) $display("[TB] FAIL fs_tick: got %b expected 1", bus.frame_tick);
        else passCount++;
        if (bus.frame_tick === 1'b1 && expQ.size() > 0) cur = expQ.pop_front();
        for (int k = 1; k < 32; k++) begin
            step();
            bus.load = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                checkCount++;
                if (bus.load_pend !== 1'b1) $display("[TB] FAIL fs_pend_kept: got %b expected 1", bus.load_pend);
                else passCount++;
            end
            if (k % DIV == 4) begin
                checkCount++;
                if (bus.seg_num !== nib(cur, k / DIV)) $display("[TB] FAIL fs_old_seg_d%0d: got %h expected %h", k / DIV, bus.seg_num, nib(cur, k / DIV));
                else passCount++;
            end
        end
        for (int i = 0; i < 40; i++) begin
            step();
            @(negedge clk);
            if (bus.frame_tick === 1'b1) begin
                checkCount++;
                if (bus.load_pend !== 1'b1) $display("[TB] FAIL fs_pend_at_tick: got %b expected 1", bus.load_pend);
                else passCount++;
                if (expQ.size() > 0) cur = expQ.pop_front();
                seen = 1'b1;
                break;
            end
        end
        checkCount++;
        if (!seen) $display("[TB] FAIL fs_tick_timeout: got no frame_tick expected one within 40 cycles");
        else passCount++;
        for (int k = 1; k < 32; k++) begin
            step();
            @(negedge clk);
            if (k == 1) begin
                checkCount++;
                if (bus.load_pend !== 1'b0) $display("[TB] FAIL fs_pend_clear: got %b expected 0", bus.load_pend);
                else passCount++;
            end
            if (k % DIV == 4) begin
                checkCount++;
                if (bus.seg_num !== nib(16'hABCD, k / DIV)) $display("[TB] FAIL fs_new_seg_d%0d: got %h expected %h", k / DIV, bus.seg_num, nib(16'hABCD, k / DIV));
                else passCount++;
                checkCount++;
                if (bus.dig_sel_n !== expSel(16'hABCD, k / DIV, 4)) $display("[TB] FAIL fs_new_sel_d%0d: got %b expected %b", k / DIV, bus.dig_sel_n, expSel(16'hABCD, k / DIV, 4));
                else passCount++;
            end
        end
    endtask

    task automatic test_enable_drop();
        step();
        @(negedge clk);
        checkCount++;
        if (bus.frame_tick !== 1'b1) $display("[TB] FAIL drop_frame_tick: got %b expected 1", bus.frame_tick);
        else passCount++;
        repeat (20) step();
        @(negedge clk);
        checkCount++;
        if (bus.dig_sel_n !== 4'b1011) $display("[TB] FAIL drop_d2_show: got %b expected %b", bus.dig_sel_n, 4'b1011);
        else passCount++;
        checkCount++;
        if (bus.seg_num !== 4'hB) $display("[TB] FAIL drop_d2_seg: got %h expected b", bus.seg_num);
        else passCount++;
        step();
        bus.enable = 1'b0;
        step();
        @(negedge clk);
        checkCount++;
        if (bus.dig_sel_n !== 4'b1111) $display("[TB] FAIL drop_dark: got %b expected %b", bus.dig_sel_n, 4'b1111);
        else passCount++;
        checkCount++;
        if (bus.frame_tick !== 1'b0) $display("[TB] FAIL drop_no_tick: got %b expected 0", bus.frame_tick);
        else passCount++;
        repeat (3) step();
        bus.enable = 1'b1;
        @(negedge clk);
        checkCount++;
        if (bus.frame_tick !== 1'b1) $display("[TB] FAIL reenable_tick: got %b expected 1", bus.frame_tick);
        else passCount++;
        checkCount++;
        if (bus.dig_sel_n !== 4'b1111) $display("[TB] FAIL reenable_blank: got %b expected %b", bus.dig_sel_n, 4'b1111);
        else passCount++;
        checkCount++;
        if (bus.seg_num !== 4'hD) $display("[TB] FAIL reenable_seg: got %h expected d", bus.seg_num);
        else passCount++;
        repeat (2) step();
        @(negedge clk);
        checkCount++;
        if (bus.dig_sel_n !== 4'b1110) $display("[TB] FAIL reenable_show: got %b expected %b", bus.dig_sel_n, 4'b1110);
        else passCount++;
    endtask

    task automatic test_lzb();
        logic [15:0] pats[2];
        bit seen;
        pats[0] = 16'h0050;
        pats[1] = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            seen = 1'b0;
            step();
            bus.load     = 1'b1;
            bus.value_in = pats[p];
            expQ.push_back(pats[p]);
            step();
            bus.load = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.frame_tick === 1'b1) begin
                    if (expQ.size() > 0) cur = expQ.pop_front();
                    seen = 1'b1;
                    break;
                end
                step();
            end
            checkCount++;
            if (!seen) $display("[TB] FAIL lzb_tick_timeout_%0d: got no frame_tick expected one within 40 cycles", p);
            else passCount++;
            for (int k = 1; k < 32; k++) begin
                step();
                @(negedge clk);
                if (k % DIV == 4) begin
                    checkCount++;
                    if (bus.seg_num !== nib(pats[p], k / DIV)) $display("[TB] FAIL lzb_seg_%h_d%0d: got %h expected %h", pats[p], k / DIV, bus.seg_num, nib(pats[p], k / DIV));
                    else passCount++;
                    checkCount++;
                    if (bus.dig_sel_n !== expSel(pats[p], k / DIV, 4)) $display("[TB] FAIL lzb_sel_%h_d%0d: got %b expected %b", pats[p], k / DIV, bus.dig_sel_n, expSel(pats[p], k / DIV, 4));
                    else passCount++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_last_load_wins();
        test_load_on_frame_start();
        test_enable_drop();
        test_lzb();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 1000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
